// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Bundles the two load/store unit buses: the request/response side toward
// execute and writeback, and the req/ack data-memory side.
//   op_*        request from the pipeline (valid, load/store, funct3, addr, wdata)
//   op_ready    unit is idle and will sample op_valid
//   mem_*       data-memory handshake (req/we/addr/wdata/wstrb out, ack/rdata in)
//   done/err    one-cycle completion pulse with error flag
//   load_data   extended load result, valid with done
// Modports: slave = the load/store unit, master = the surrounding pipeline/memory.
interface load_store_unit_if;
    logic        op_valid;
    logic        op_ready;
    logic        op_load;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        done;
    logic        err;
    logic [31:0] load_data;

    modport slave (
        input  op_valid, op_load, op_store, op_funct3, op_addr, op_wdata,
        input  mem_ack, mem_rdata,
        output op_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output done, err, load_data
    );

    modport master (
        output op_valid, op_load, op_store, op_funct3, op_addr, op_wdata,
        output mem_ack, mem_rdata,
        input  op_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  done, err, load_data
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-access stage after the ALU: runs one load or store per request over
// a req/ack data-memory handshake, steering byte lanes and strobes on stores
// and extracting/extending the addressed lanes on loads.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        load_store_unit_if.slave (request, memory and response signals)
// Parameters:
//   ACK_TIMEOUT  ACCESS cycles without mem_ack before aborting with err; 0 = never
// Optional build macro:
//   MISALIGN_TRAP_EN  misaligned half/word requests finish with err=1 and no
//                     memory access; when undefined the low offset bits are ignored.
//
// state  | meaning
// IDLE   | op_ready=1, waiting for op_valid
// ACCESS | mem_req held with stable address/data/strobes until mem_ack or timeout
// RESP   | done=1 for one cycle with err/load_data
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam bit          TO_EN = (ACK_TIMEOUT != 0);
    localparam int          CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    // Timeout fires on the cycle whose increment would reach ACK_TIMEOUT,
    // so mem_req stays high for exactly ACK_TIMEOUT cycles.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_req;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic [1:0]         r_off;
    logic [2:0]         r_f3;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [31:0]        r_ld;

    logic               w_is_b;
    logic               w_is_h;
    logic               w_is_w;
    logic               w_f3_ok;
    logic               w_kind_ok;
    logic               w_bad;
    logic [1:0]         w_off;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_wdata;
    logic               w_accept;
    logic               w_reject;
    logic               w_ack;
    logic               w_tmo;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_extract;

    // Request decode
    assign w_is_b    = (bus.op_funct3[1:0] == 2'b00);
    assign w_is_h    = (bus.op_funct3[1:0] == 2'b01);
    assign w_is_w    = (bus.op_funct3[1:0] == 2'b10);
    assign w_f3_ok   = (bus.op_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_kind_ok = bus.op_load ^ bus.op_store;

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = (w_is_h & bus.op_addr[0]) | (w_is_w & (bus.op_addr[1:0] != 2'b00));
    assign w_bad      = ~w_kind_ok | ~w_f3_ok | w_misalign;
`else
    assign w_bad      = ~w_kind_ok | ~w_f3_ok;
`endif

    // Lane offset; misaligned low bits are dropped for half/word.
    always_comb begin
        w_off = 2'b00;
        if (w_is_b)
            w_off = bus.op_addr[1:0];
        else if (w_is_h)
            w_off = {bus.op_addr[1], 1'b0};
    end

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (bus.op_store) begin
            if (w_is_b) begin
                w_wstrb = 4'b0001 << w_off;
                w_wdata = {4{bus.op_wdata[7:0]}};
            end else if (w_is_h) begin
                w_wstrb = 4'b0011 << w_off;
                w_wdata = {2{bus.op_wdata[15:0]}};
            end else begin
                w_wstrb = 4'b1111;
                w_wdata = bus.op_wdata;
            end
        end
    end

    // Load extraction from the returned word
    always_comb begin
        case (r_off)
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_f3)
            3'b000:  w_extract = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_extract = {24'h0, w_byte};
            3'b001:  w_extract = {{16{w_half[15]}}, w_half};
            3'b101:  w_extract = {16'h0, w_half};
            default: w_extract = bus.mem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state and event decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_ack       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.op_valid) begin
                    if (w_bad) begin
                        w_reject    = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack coincident with the timeout takes priority.
                if (bus.mem_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = RESP;
                end else if (TO_EN && (r_cnt == TO_LAST)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wstrb <= 4'b0000;
            r_off   <= 2'b00;
            r_f3    <= 3'b000;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_ld    <= 32'h0;
        end else begin
            if (w_accept) begin
                r_req   <= 1'b1;
                r_we    <= bus.op_store;
                r_addr  <= {bus.op_addr[31:2], 2'b00};
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
                r_off   <= w_off;
                r_f3    <= bus.op_funct3;
                r_cnt   <= '0;
            end
            if (w_reject) begin
                r_err <= 1'b1;
                r_ld  <= 32'h0;
            end
            if (r_state == ACCESS) begin
                if (w_ack) begin
                    r_req <= 1'b0;
                    r_err <= 1'b0;
                    r_ld  <= r_we ? 32'h0 : w_extract;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_tmo) begin
                        r_req <= 1'b0;
                        r_err <= 1'b1;
                        r_ld  <= 32'h0;
                    end
                end
            end
        end
    end

    assign bus.op_ready  = (r_state == IDLE);
    assign bus.done      = (r_state == RESP);
    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wstrb = r_wstrb;
    assign bus.err       = r_err;
    assign bus.load_data = r_ld;
endmodule
